pc_call_stack: RTL and testbench

Parametrised program counter for the RISC CPU, with a hardware return-address stack, conditional skip, absolute jump and optional PC-relative branch. It replaces the fixed 5-bit counter in the fetch path. The controller issues one `pc_op` per instruction, qualified by `load_in`. `program_counter` drives the instruction-memory address mux.

---
 rtl/pc_call_stack.sv | 102 ++++++++++
 tb/tb_pc_call_stack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with return-address stack, skip, jump, call/return.
// Optional PC-relative BRANCH on opcode 110 when PC_REL_BRANCH_EN is defined.
module pc_call_stack #(
    parameter int              ADDR_W       = 5,
    parameter int              STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               en_cpu_in,
    input  logic                               load_in,
    input  logic [2:0]                         pc_op,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               skz_cmp,
    input  logic                               clr_err,
    output logic [ADDR_W-1:0]                  program_counter,
    output logic [ADDR_W-1:0]                  ret_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_ptr,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               overflow,
    output logic                               underflow
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_SKIP   = 3'b010;
    localparam logic [2:0] OP_JUMP   = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
`ifdef PC_REL_BRANCH_EN
    localparam logic [2:0] OP_BRANCH = 3'b110;
`endif

    logic [ADDR_W-1:0] entries [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

    assign pc_inc      = program_counter + 1'b1;
    assign wr_idx      = IDX_W'(stack_ptr);
    assign top_idx     = IDX_W'(stack_ptr - 1'b1);
    assign stack_empty = stack_ptr == '0;
    assign stack_full  = stack_ptr == SP_W'(STACK_DEPTH);
    assign ret_addr    = stack_empty ? '0 : entries[top_idx];

    // Opcodes 001, 111 and (without the branch feature) 110 all fall to INC.
    always_comb begin
        next_pc = program_counter;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en_cpu_in && load_in) begin
            case (pc_op)
                OP_HOLD: next_pc = program_counter;
                OP_SKIP: next_pc = skz_cmp ? program_counter + ADDR_W'(2) : pc_inc;
                OP_JUMP: next_pc = addr;
                OP_CALL: begin
                    next_pc = addr;
                    push    = !stack_full;
                    ovf_set = stack_full;
                end
                OP_RET: begin
                    next_pc = stack_empty ? pc_inc : ret_addr;
                    pop     = !stack_empty;
                    unf_set = stack_empty;
                end
`ifdef PC_REL_BRANCH_EN
                // Same-width add is the sign-extended offset taken modulo 2^ADDR_W.
                OP_BRANCH: next_pc = program_counter + addr;
`endif
                default: next_pc = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            program_counter <= RESET_VECTOR;
            stack_ptr       <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            program_counter <= next_pc;
            stack_ptr       <= stack_ptr + SP_W'(push) - SP_W'(pop);
            overflow        <= ovf_set | (overflow & ~clr_err);
            underflow       <= unf_set | (underflow & ~clr_err);
        end
    end

    // Contents are never cleared; they are only visible below stack_ptr.
    always_ff @(posedge clock) begin
        if (push && !reset)
            entries[wr_idx] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed plan plus randomized steps checked against a queue-based model.
module tb_pc_call_stack;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       en_cpu_in;
    logic       load_in;
    logic [2:0] pc_op;
    logic [4:0] addr;
    logic       skz_cmp;
    logic       clr_err;
    logic [4:0] program_counter;
    logic [4:0] ret_addr;
    logic [2:0] stack_ptr;
    logic       stack_empty;
    logic       stack_full;
    logic       overflow;
    logic       underflow;

    pc_call_stack #(.ADDR_W(5), .STACK_DEPTH(DEPTH), .RESET_VECTOR(5'd0)) dut (
        .clock(clock), .reset(reset), .en_cpu_in(en_cpu_in), .load_in(load_in),
        .pc_op(pc_op), .addr(addr), .skz_cmp(skz_cmp), .clr_err(clr_err),
        .program_counter(program_counter), .ret_addr(ret_addr), .stack_ptr(stack_ptr),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [4:0] m_pc;
    logic [4:0] m_q [$];
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"}, 32'(program_counter), 32'(m_pc));
        chk({tag, "_sp"}, 32'(stack_ptr), 32'(m_q.size()));
        chk({tag, "_ret"}, 32'(ret_addr), m_q.size() == 0 ? 32'd0 : 32'(m_q[m_q.size()-1]));
        chk({tag, "_empty"}, 32'(stack_empty), 32'(m_q.size() == 0));
        chk({tag, "_full"}, 32'(stack_full), 32'(m_q.size() == DEPTH));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 5'd0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model(input logic e, input logic l, input logic [2:0] op,
                         input logic [4:0] a, input logic s, input logic c);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (e && l) begin
            case (op)
                3'd0: ;
                3'd2: m_pc = m_pc + (s ? 5'd2 : 5'd1);
                3'd3: m_pc = a;
                3'd4: begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_pc + 5'd1);
                    else m_ovf = 1'b1;
                    m_pc = a;
                end
                3'd5: begin
                    if (m_q.size() == 0) begin
                        m_pc = m_pc + 5'd1;
                        m_unf = 1'b1;
                    end else m_pc = m_q.pop_back();
                end
`ifdef PC_REL_BRANCH_EN
                3'd6: m_pc = m_pc + a;
`endif
                default: m_pc = m_pc + 5'd1;
            endcase
        end
    endtask

    task automatic step(input logic e, input logic l, input logic [2:0] op, input logic [4:0] a,
                        input logic s, input logic c, input string tag);
        en_cpu_in = e;
        load_in   = l;
        pc_op     = op;
        addr      = a;
        skz_cmp   = s;
        clr_err   = c;
        model(e, l, op, a, s, c);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic rst_pulse(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all({tag, "_held"});
    endtask

    initial begin
        reset = 1'b1;
        en_cpu_in = 1'b0;
        load_in = 1'b0;
        pc_op = 3'd0;
        addr = 5'd0;
        skz_cmp = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: gating and reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0, "t1_dis");
        chk("t1_dis_pc0", 32'(program_counter), 32'd0);
        step(1'b1, 1'b0, 3'd3, 5'd17, 1'b0, 1'b0, "t1_noload");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0, "t1_inc");
        chk("t1_pc3", 32'(program_counter), 32'd3);
        en_cpu_in = 1'b1; load_in = 1'b1; pc_op = 3'd4; addr = 5'd9;
        rst_pulse("t1_midrst");
        chk("t1_midrst_pc0", 32'(program_counter), 32'd0);

        // 2: jump, wrap, skip
        step(1'b1, 1'b1, 3'd3, 5'd30, 1'b0, 1'b0, "t2_jump");
        chk("t2_pc30", 32'(program_counter), 32'd30);
        step(1'b1, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0, "t2_inc31");
        step(1'b1, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0, "t2_wrap");
        chk("t2_pc0", 32'(program_counter), 32'd0);
        step(1'b1, 1'b1, 3'd3, 5'd31, 1'b0, 1'b0, "t2_j31");
        step(1'b1, 1'b1, 3'd2, 5'd0, 1'b1, 1'b0, "t2_skip1");
        chk("t2_pc1", 32'(program_counter), 32'd1);
        step(1'b1, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0, "t2_skip0");
        chk("t2_pc2", 32'(program_counter), 32'd2);

        // 3: nested call/return
        step(1'b1, 1'b1, 3'd3, 5'd5, 1'b0, 1'b0, "t3_j5");
        step(1'b1, 1'b1, 3'd4, 5'd10, 1'b0, 1'b0, "t3_call10");
        step(1'b1, 1'b1, 3'd4, 5'd20, 1'b0, 1'b0, "t3_call20");
        chk("t3_ret11", 32'(ret_addr), 32'd11);
        chk("t3_sp2", 32'(stack_ptr), 32'd2);
        step(1'b1, 1'b1, 3'd5, 5'd0, 1'b0, 1'b0, "t3_ret1");
        chk("t3_pc11", 32'(program_counter), 32'd11);
        step(1'b1, 1'b1, 3'd5, 5'd0, 1'b0, 1'b0, "t3_ret2");
        chk("t3_pc6", 32'(program_counter), 32'd6);

        // 4: overflow
        step(1'b1, 1'b1, 3'd3, 5'd0, 1'b0, 1'b0, "t4_j0");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd4, 5'd8, 1'b0, 1'b0, "t4_call");
        chk("t4_full", 32'(stack_full), 32'd1);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_sp4", 32'(stack_ptr), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd5, 5'd0, 1'b0, 1'b0, "t4_ret");
        chk("t4_pc1", 32'(program_counter), 32'd1);

        // 5: underflow and clear
        step(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, "t5_clr_ovf");
        step(1'b1, 1'b1, 3'd3, 5'd12, 1'b0, 1'b0, "t5_j12");
        step(1'b1, 1'b1, 3'd5, 5'd0, 1'b0, 1'b0, "t5_unf");
        chk("t5_pc13", 32'(program_counter), 32'd13);
        chk("t5_unf1", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, "t5_clr");
        chk("t5_unf0", 32'(underflow), 32'd0);
        step(1'b1, 1'b1, 3'd5, 5'd0, 1'b0, 1'b1, "t5_setwins");
        chk("t5_unf_keep", 32'(underflow), 32'd1);

        // 6: branch (or INC in the default build)
        step(1'b1, 1'b1, 3'd3, 5'd4, 1'b0, 1'b0, "t6_j4");
        step(1'b1, 1'b1, 3'd6, 5'b11110, 1'b0, 1'b0, "t6_br_m2");
        step(1'b1, 1'b1, 3'd6, 5'd3, 1'b0, 1'b0, "t6_br_p3");
`ifdef PC_REL_BRANCH_EN
        chk("t6_pc5", 32'(program_counter), 32'd5);
`else
        chk("t6_pc6", 32'(program_counter), 32'd6);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) rst_pulse("rnd_rst");
            else step($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                      3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom),
                      $urandom_range(0, 9) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
